// File: rtl/lfsr_parity_pkg.sv
// Shared definitions for the 7-bit LFSR pattern generator and its receive-side checker.
package lfsr_parity_pkg;

   localparam int               LFSR_W = 7;
   localparam logic [LFSR_W-1:0] SEED  = 7'h01;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   // Word bit 7 is set when the state holds an even number of ones.
   function automatic logic parity_bit(input logic [LFSR_W-1:0] s);
      return ~^s;
   endfunction

endpackage

// File: rtl/lfsr_parity_checker_predictor.sv
// Holds the expected LFSR state: re-seeded from a received word or free-running (flywheel).
import lfsr_parity_pkg::*;

module lfsr_predictor (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              advance,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] expected
);

   logic [LFSR_W-1:0] expected_q;
   logic [LFSR_W-1:0] expected_d;

   always_comb begin
      expected_d = expected_q;
      if (load) begin
         expected_d = lfsr_next(seed);
      end else if (advance) begin
         expected_d = lfsr_next(expected_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expected_q <= '0;
      end else begin
         expected_q <= expected_d;
      end
   end

   assign expected = expected_q;

endmodule

// File: rtl/lfsr_parity_checker.sv
// Receive-side LFSR + parity checker: parity check, self-sync lock FSM, saturating error count.
// Optional sticky error flag built only with LFSR_CHK_STICKY_EN defined.
//
// state  | meaning
// HUNT   | seeding from received words, counting consecutive correct predictions
// LOCKED | flywheel prediction, flagging and counting sequence mismatches
import lfsr_parity_pkg::*;

module lfsr_parity_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       data_in,
   input  logic             valid_in,
   input  logic             clear,
   output logic             locked,
   output logic             parity_err,
   output logic             seq_err,
   output logic [CNT_W-1:0] err_count,
   output logic             err_sticky
);

   chk_state_e       state_q, state_d;
   logic [4:0]       match_cnt_q, match_cnt_d;
   logic [3:0]       miss_cnt_q, miss_cnt_d;
   logic             locked_q, locked_d;
   logic             parity_err_q, parity_err_d;
   logic             seq_err_q, seq_err_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic [LFSR_W-1:0] word_s;
   logic [LFSR_W-1:0] expected;
   logic              par_bad;
   logic              pred_hit;
   logic              pred_load;
   logic              pred_adv;

   assign word_s   = data_in[LFSR_W-1:0];
   assign par_bad  = data_in[7] != parity_bit(word_s);
   assign pred_hit = word_s == expected;

   lfsr_predictor u_pred (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pred_load),
      .advance  (pred_adv),
      .seed     (word_s),
      .expected (expected)
   );

   always_comb begin
      state_d      = state_q;
      match_cnt_d  = match_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      locked_d     = locked_q;
      parity_err_d = 1'b0;
      seq_err_d    = 1'b0;
      err_count_d  = err_count_q;
      pred_load    = 1'b0;
      pred_adv     = 1'b0;

      if (clear) begin
         state_d     = HUNT;
         match_cnt_d = '0;
         miss_cnt_d  = '0;
         locked_d    = 1'b0;
         err_count_d = '0;
      end else if (valid_in) begin
         parity_err_d = par_bad;
         case (state_q)
            HUNT: begin
               if (!par_bad && (word_s != '0)) begin
                  pred_load = 1'b1;
                  if (pred_hit && (match_cnt_q != '0)) begin
                     match_cnt_d = match_cnt_q + 5'd1;
                  end else begin
                     match_cnt_d = 5'd1;
                  end
                  // One seed word plus LOCK_CNT confirmations.
                  if (match_cnt_d == 5'(LOCK_CNT + 1)) begin
                     state_d    = LOCKED;
                     locked_d   = 1'b1;
                     miss_cnt_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               pred_adv = 1'b1;
               if (!pred_hit) begin
                  seq_err_d  = 1'b1;
                  miss_cnt_d = miss_cnt_q + 4'd1;
                  if (miss_cnt_d == 4'(LOSS_CNT)) begin
                     state_d     = HUNT;
                     locked_d    = 1'b0;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end
               end else begin
                  miss_cnt_d = '0;
               end
            end
            default: begin
               state_d  = HUNT;
               locked_d = 1'b0;
            end
         endcase
         if ((parity_err_d || seq_err_d) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         locked_q     <= 1'b0;
         parity_err_q <= 1'b0;
         seq_err_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         locked_q     <= locked_d;
         parity_err_q <= parity_err_d;
         seq_err_q    <= seq_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign locked     = locked_q;
   assign parity_err = parity_err_q;
   assign seq_err    = seq_err_q;
   assign err_count  = err_count_q;

`ifdef LFSR_CHK_STICKY_EN
   logic err_sticky_q, err_sticky_d;

   always_comb begin
      err_sticky_d = err_sticky_q | parity_err_d | seq_err_d;
      if (clear) begin
         err_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky_q <= 1'b0;
      end else begin
         err_sticky_q <= err_sticky_d;
      end
   end

   assign err_sticky = err_sticky_q;
`else
   assign err_sticky = 1'b0;
`endif

endmodule
